// File: rtl/morse_encoder.sv
// Morse code keyer: accepts one 6-bit character code at a time and keys
// it out as marks and gaps timed in units of UNIT_CYCLES clocks.
// Codes 0-25 are A-Z, 26-35 are digits 0-9, 36 is a word space, and
// 37-63 are rejected with a code_err pulse.
module morse_encoder #(
  parameter int unsigned UNIT_CYCLES = 5000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       char_valid,
  input  logic [5:0] char_code,
  output logic       char_ready,
  output logic       key_out,
  output logic [1:0] symbol_out,
  output logic       busy,
  output logic       char_done,
  output logic       code_err
);

  // The longest interval is the 4-unit word space, so size the counter for it.
  localparam int unsigned CNT_W = $clog2(4 * UNIT_CYCLES + 1);

  // Counters load "duration - 1" and count down to zero.
  localparam logic [CNT_W-1:0] DOT_LAST  = CNT_W'(UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DASH_LAST = CNT_W'(3 * UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(4 * UNIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MARK     = 2'd1,
    S_ELEM_GAP = 2'd2,
    S_CHAR_GAP = 2'd3
  } state_t;

  // Pattern ROM: {length[2:0], elements[4:0]}. Elements are left-aligned,
  // so bit 4 is the first element sent; 1 = dash, 0 = dot.
  function automatic logic [7:0] morse_lut(input logic [5:0] code);
    logic [7:0] e;
    case (code)
      6'd0:  e = {3'd2, 5'b01000}; // A .-
      6'd1:  e = {3'd4, 5'b10000}; // B -...
      6'd2:  e = {3'd4, 5'b10100}; // C -.-.
      6'd3:  e = {3'd3, 5'b10000}; // D -..
      6'd4:  e = {3'd1, 5'b00000}; // E .
      6'd5:  e = {3'd4, 5'b00100}; // F ..-.
      6'd6:  e = {3'd3, 5'b11000}; // G --.
      6'd7:  e = {3'd4, 5'b00000}; // H ....
      6'd8:  e = {3'd2, 5'b00000}; // I ..
      6'd9:  e = {3'd4, 5'b01110}; // J .---
      6'd10: e = {3'd3, 5'b10100}; // K -.-
      6'd11: e = {3'd4, 5'b01000}; // L .-..
      6'd12: e = {3'd2, 5'b11000}; // M --
      6'd13: e = {3'd2, 5'b10000}; // N -.
      6'd14: e = {3'd3, 5'b11100}; // O ---
      6'd15: e = {3'd4, 5'b01100}; // P .--.
      6'd16: e = {3'd4, 5'b11010}; // Q --.-
      6'd17: e = {3'd3, 5'b01000}; // R .-.
      6'd18: e = {3'd3, 5'b00000}; // S ...
      6'd19: e = {3'd1, 5'b10000}; // T -
      6'd20: e = {3'd3, 5'b00100}; // U ..-
      6'd21: e = {3'd4, 5'b00010}; // V ...-
      6'd22: e = {3'd3, 5'b01100}; // W .--
      6'd23: e = {3'd4, 5'b10010}; // X -..-
      6'd24: e = {3'd4, 5'b10110}; // Y -.--
      6'd25: e = {3'd4, 5'b11000}; // Z --..
      6'd26: e = {3'd5, 5'b11111}; // 0 -----
      6'd27: e = {3'd5, 5'b01111}; // 1 .----
      6'd28: e = {3'd5, 5'b00111}; // 2 ..---
      6'd29: e = {3'd5, 5'b00011}; // 3 ...--
      6'd30: e = {3'd5, 5'b00001}; // 4 ....-
      6'd31: e = {3'd5, 5'b00000}; // 5 .....
      6'd32: e = {3'd5, 5'b10000}; // 6 -....
      6'd33: e = {3'd5, 5'b11000}; // 7 --...
      6'd34: e = {3'd5, 5'b11100}; // 8 ---..
      6'd35: e = {3'd5, 5'b11110}; // 9 ----.
      default: e = 8'h00;
    endcase
    return e;
  endfunction

  // True when element idx (0 = first) of a looked-up pattern is a dash.
  function automatic logic elem_dash(input logic [7:0] lut, input logic [2:0] idx);
    return lut[3'd4 - idx];
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [5:0]       code_q, code_d;

  logic             key_q, key_d;
  logic [1:0]       sym_q, sym_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic [7:0]       lut_acc, lut_cur, lut_nxt;

  assign lut_acc = morse_lut(char_code);
  assign lut_cur = morse_lut(code_q);
  assign lut_nxt = morse_lut(code_d);

  // State, counters and held code.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      code_q  <= code_d;
    end
  end

  // Next-state: sequence marks and gaps, loading each interval's length on entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    code_d  = code_q;
    case (state_q)
      S_IDLE: begin
        if (char_valid) begin
          code_d = char_code;
          if (char_code < 6'd36) begin
            state_d = S_MARK;
            idx_d   = 3'd0;
            cnt_d   = elem_dash(lut_acc, 3'd0) ? DASH_LAST : DOT_LAST;
          end else if (char_code == 6'd36) begin
            state_d = S_CHAR_GAP;
            cnt_d   = WORD_LAST;
          end
        end
      end
      S_MARK: begin
        if (cnt_q == '0) begin
          if ((idx_q + 3'd1) < lut_cur[7:5]) begin
            state_d = S_ELEM_GAP;
            cnt_d   = DOT_LAST;
            idx_d   = idx_q + 3'd1;
          end else begin
            state_d = S_CHAR_GAP;
            cnt_d   = DASH_LAST;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_ELEM_GAP: begin
        if (cnt_q == '0) begin
          state_d = S_MARK;
          cnt_d   = elem_dash(lut_cur, idx_q) ? DASH_LAST : DOT_LAST;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_CHAR_GAP: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          idx_d   = 3'd0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the upcoming state so every output leaves a flop.
  always_comb begin
    key_d   = (state_d == S_MARK);
    sym_d   = 2'b00;
    if (state_d == S_MARK) begin
      sym_d = elem_dash(lut_nxt, idx_d) ? 2'b10 : 2'b01;
    end
    ready_d = (state_d == S_IDLE);
    done_d  = (state_q == S_CHAR_GAP) && (state_d == S_IDLE);
    err_d   = (state_q == S_IDLE) && char_valid && (char_code > 6'd36);
  end

  // Output registers; reset forces the idle/ready presentation at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_q   <= 1'b0;
      sym_q   <= 2'b00;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      key_q   <= key_d;
      sym_q   <= sym_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign key_out    = key_q;
  assign symbol_out = sym_q;
  assign char_ready = ready_q;
  assign busy       = ~ready_q;
  assign char_done  = done_q;
  assign code_err   = err_q;

endmodule

// File: tb/tb_morse_encoder.sv
// Testbench for morse_encoder with UNIT_CYCLES=4. A cycle-indexed model,
// built from dot/dash strings, predicts every output on every cycle;
// directed runs add hand-computed timing expectations.
module tb_morse_encoder;

  localparam int U    = 4;
  localparam int MAXC = 1000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       char_valid = 1'b0;
  logic [5:0] char_code = 6'd0;
  logic       char_ready, key_out, busy, char_done, code_err;
  logic [1:0] symbol_out;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  morse_encoder #(.UNIT_CYCLES(U)) dut (
    .clk        (clk),
    .rst        (rst),
    .char_valid (char_valid),
    .char_code  (char_code),
    .char_ready (char_ready),
    .key_out    (key_out),
    .symbol_out (symbol_out),
    .busy       (busy),
    .char_done  (char_done),
    .code_err   (code_err)
  );

  always #5 clk = ~clk;

  // Cycle numbering: cyc = k during the cycle following the k-th rising edge.
  always @(posedge clk) cyc = cyc + 1;

  string MORSE [0:35] = '{
    ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
    "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
    "..-", "...-", ".--", "-..-", "-.--", "--..",
    "-----", ".----", "..---", "...--", "....-",
    ".....", "-....", "--...", "---..", "----."
  };

  bit         exp_key   [MAXC];
  logic [1:0] exp_sym   [MAXC];
  bit         exp_ready [MAXC];
  bit         exp_done  [MAXC];
  bit         exp_err   [MAXC];

  function automatic void model_clear(input int from);
    for (int i = from; i < MAXC; i++) begin
      exp_key[i] = 1'b0; exp_sym[i] = 2'b00; exp_ready[i] = 1'b1;
      exp_done[i] = 1'b0; exp_err[i] = 1'b0;
    end
  endfunction

  function automatic void put(input int t, input bit k, input logic [1:0] s, input bit r);
    if (t < MAXC) begin
      exp_key[t] = k; exp_sym[t] = s; exp_ready[t] = r;
    end
  endfunction

  // Character presented in cycle c is accepted at the edge ending cycle c.
  function automatic void model_char(input int c, input int code);
    int t;
    string s;
    t = c + 1;
    if (code < 36) begin
      s = MORSE[code];
      for (int i = 0; i < s.len(); i++) begin
        bit dash;
        int d;
        dash = (s.getc(i) == "-");
        d = dash ? 3 * U : U;
        for (int k = 0; k < d; k++) begin
          put(t, 1'b1, dash ? 2'b10 : 2'b01, 1'b0); t++;
        end
        if (i < s.len() - 1) begin
          for (int k = 0; k < U; k++) begin put(t, 1'b0, 2'b00, 1'b0); t++; end
        end
      end
      for (int k = 0; k < 3 * U; k++) begin put(t, 1'b0, 2'b00, 1'b0); t++; end
      if (t < MAXC) exp_done[t] = 1'b1;
    end else if (code == 36) begin
      for (int k = 0; k < 4 * U; k++) begin put(t, 1'b0, 2'b00, 1'b0); t++; end
      if (t < MAXC) exp_done[t] = 1'b1;
    end else begin
      if (t < MAXC) exp_err[t] = 1'b1;
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, cyc, act, req);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (cyc < MAXC) begin
      chk("key_out",    32'(key_out),    32'(exp_key[cyc]));
      chk("symbol_out", 32'(symbol_out), 32'(exp_sym[cyc]));
      chk("char_ready", 32'(char_ready), 32'(exp_ready[cyc]));
      chk("busy",       32'(busy),       32'(!exp_ready[cyc]));
      chk("char_done",  32'(char_done),  32'(exp_done[cyc]));
      chk("code_err",   32'(code_err),   32'(exp_err[cyc]));
    end
  end

  // Present one code for a single cycle, then observe span cycles.
  task automatic run_char(input logic [5:0] code, input int span,
                          output int nkey, output int first_key,
                          output int done_at, output int err_at);
    int c;
    @(negedge clk);
    c = cyc;
    char_valid = 1'b1;
    char_code  = code;
    model_char(c, int'(code));
    nkey = 0; first_key = -1; done_at = -1; err_at = -1;
    for (int r = 1; r <= span; r++) begin
      @(negedge clk);
      if (r == 1) begin
        char_valid = 1'b0;
        char_code  = 6'd20;
      end
      if (key_out === 1'b1) begin
        nkey++;
        if (first_key < 0) first_key = r;
      end
      if (char_done === 1'b1 && done_at < 0) done_at = r;
      if (code_err === 1'b1 && err_at < 0) err_at = r;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nkey, fk, dn, er, ndone, c;
    model_clear(0);

    // Reset state, checked while rst is held.
    @(negedge clk);
    chk("rst_char_ready", 32'(char_ready), 32'd1);
    chk("rst_busy",       32'(busy),       32'd0);
    chk("rst_key_out",    32'(key_out),    32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // 'E'
    run_char(6'd4, 20, nkey, fk, dn, er);
    chk("E_mark_cycles", 32'(nkey), 32'd4);
    chk("E_first_key",   32'(fk),   32'd1);
    chk("E_done_cycle",  32'(dn),   32'd17);

    // 'A'
    run_char(6'd0, 36, nkey, fk, dn, er);
    chk("A_mark_cycles", 32'(nkey), 32'd16);
    chk("A_done_cycle",  32'(dn),   32'd33);

    // '0'
    run_char(6'd26, 92, nkey, fk, dn, er);
    chk("0_mark_cycles", 32'(nkey), 32'd60);
    chk("0_done_cycle",  32'(dn),   32'd89);

    // Invalid code 40
    run_char(6'd40, 20, nkey, fk, dn, er);
    chk("err_cycle",     32'(er),   32'd1);
    chk("err_no_key",    32'(nkey), 32'd0);
    chk("err_no_done",   32'(dn),   32'hFFFF_FFFF);

    // Word space then 'T' with char_valid held; code changes while busy.
    @(negedge clk);
    c = cyc;
    char_valid = 1'b1;
    char_code  = 6'd36;
    model_char(c, 36);
    model_char(c + 17, 19);
    nkey = 0; fk = -1; dn = -1; ndone = 0;
    for (int r = 1; r <= 45; r++) begin
      @(negedge clk);
      if (r == 1) char_code = 6'd19;
      if (r == 18) begin char_valid = 1'b0; char_code = 6'd4; end
      if (key_out === 1'b1) begin nkey++; if (fk < 0) fk = r; end
      if (char_done === 1'b1) begin ndone++; if (dn < 0) dn = r; end
    end
    chk("sp_done_cycle", 32'(dn),    32'd17);
    chk("T_first_key",   32'(fk),    32'd18);
    chk("T_mark_cycles", 32'(nkey),  32'd12);
    chk("sp_T_dones",    32'(ndone), 32'd2);

    // Reset in cycle 6 of a dash ('T').
    @(negedge clk);
    c = cyc;
    char_valid = 1'b1;
    char_code  = 6'd19;
    model_char(c, 19);
    @(negedge clk);
    char_valid = 1'b0;
    while (cyc != c + 6) begin
      @(posedge clk);
      #1;
    end
    model_clear(c + 6);
    rst = 1'b1;
    #1;
    chk("midrst_key_out",    32'(key_out),    32'd0);
    chk("midrst_char_ready", 32'(char_ready), 32'd1);
    chk("midrst_symbol",     32'(symbol_out), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // 'E' after reset must be timed exactly as before; no stray char_done.
    run_char(6'd4, 20, nkey, fk, dn, er);
    chk("E2_mark_cycles", 32'(nkey), 32'd4);
    chk("E2_first_key",   32'(fk),   32'd1);
    chk("E2_done_cycle",  32'(dn),   32'd17);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
